// File: rtl/pb_conditioner.sv
// Pushbutton front end: per-button synchroniser, debouncer and press/auto-repeat
// pulse generator. All outputs are registered on clk.
module pb_conditioner #(
    parameter int                NUM_PB         = 8,
    parameter int                DEBOUNCE_TICKS = 3,
    parameter int                REPEAT_DELAY   = 50,
    parameter int                REPEAT_PERIOD  = 10,
    parameter logic [NUM_PB-1:0] REPEAT_MASK    = 8'b0111_1100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_PB-1:0] pb_raw,
    output logic [NUM_PB-1:0] pb_level,
    output logic [NUM_PB-1:0] pb_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    localparam int CW   = $clog2(DEBOUNCE_TICKS + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_TICKS - 1);
    localparam logic [CW-1:0] DB_ONE  = CW'(1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic [RW-1:0] R_ONE   = RW'(1);

    genvar g;
    generate
        for (g = 0; g < NUM_PB; g++) begin : g_pb
            localparam logic REP_EN = REPEAT_MASK[g];

            logic          sync1_r;
            logic          sync2_r;
            logic          level_r;
            logic          pulse_r;
            logic [CW-1:0] dcnt_r;
            logic [RW-1:0] rcnt_r;
            state_t        state_r;
            logic          level_next_s;
            logic [CW-1:0] dcnt_next_s;

            // Debounce: level follows the synchronised input only after it has
            // disagreed for DEBOUNCE_TICKS consecutive cycles.
            always_comb begin
                level_next_s = level_r;
                dcnt_next_s  = '0;
                if (sync2_r == level_r) begin
                    level_next_s = level_r;
                    dcnt_next_s  = '0;
                end else if (dcnt_r == DB_LAST) begin
                    level_next_s = sync2_r;
                    dcnt_next_s  = '0;
                end else begin
                    level_next_s = level_r;
                    dcnt_next_s  = dcnt_r + DB_ONE;
                end
            end

            // Synchroniser, debounce state and press/repeat FSM. The FSM looks at the
            // next level so the press pulse lands in the same cycle the level rises.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    sync1_r <= 1'b0;
                    sync2_r <= 1'b0;
                    level_r <= 1'b0;
                    pulse_r <= 1'b0;
                    dcnt_r  <= '0;
                    rcnt_r  <= '0;
                    state_r <= ST_IDLE;
                end else begin
                    sync1_r <= pb_raw[g];
                    sync2_r <= sync1_r;
                    dcnt_r  <= dcnt_next_s;
                    level_r <= level_next_s;
                    pulse_r <= 1'b0;
                    case (state_r)
                        ST_IDLE: begin
                            if (level_next_s) begin
                                pulse_r <= 1'b1;
                                state_r <= ST_HELD;
                                rcnt_r  <= '0;
                            end else begin
                                state_r <= ST_IDLE;
                                rcnt_r  <= '0;
                            end
                        end
                        ST_HELD: begin
                            if (!level_next_s) begin
                                state_r <= ST_IDLE;
                                rcnt_r  <= '0;
                            end else if (!REP_EN) begin
                                state_r <= ST_HELD;
                                rcnt_r  <= '0;
                            end else if (rcnt_r == RD_LAST) begin
                                pulse_r <= 1'b1;
                                state_r <= ST_REPEAT;
                                rcnt_r  <= '0;
                            end else begin
                                state_r <= ST_HELD;
                                rcnt_r  <= rcnt_r + R_ONE;
                            end
                        end
                        ST_REPEAT: begin
                            if (!level_next_s) begin
                                state_r <= ST_IDLE;
                                rcnt_r  <= '0;
                            end else if (rcnt_r == RP_LAST) begin
                                pulse_r <= 1'b1;
                                state_r <= ST_REPEAT;
                                rcnt_r  <= '0;
                            end else begin
                                state_r <= ST_REPEAT;
                                rcnt_r  <= rcnt_r + R_ONE;
                            end
                        end
                        default: begin
                            state_r <= ST_IDLE;
                            rcnt_r  <= '0;
                        end
                    endcase
                end
            end

            assign pb_level[g] = level_r;
            assign pb_pulse[g] = pulse_r;
        end
    endgenerate

endmodule

// File: tb/tb_pb_conditioner.sv
// Self-checking bench for pb_conditioner: directed scenarios plus random button
// activity compared cycle by cycle against a sample-window reference model.
module tb_pb_conditioner;

    localparam int             NUM_PB = 8;
    localparam int             DT     = 3;
    localparam int             RD     = 50;
    localparam int             RP     = 10;
    localparam logic [7:0]     MASK   = 8'b0111_1100;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pb_raw;
    logic [7:0] pb_level;
    logic [7:0] pb_pulse;

    pb_conditioner #(
        .NUM_PB(NUM_PB), .DEBOUNCE_TICKS(DT), .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP), .REPEAT_MASK(MASK)
    ) dut (
        .clk(clk), .reset(reset), .pb_raw(pb_raw),
        .pb_level(pb_level), .pb_pulse(pb_pulse)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int t      = 0;
    int t0     = 0;

    // reference model state
    logic [7:0] rq[$];
    logic [7:0] sq[$];
    logic [7:0] m_level = 8'h00;
    logic [7:0] m_pulse = 8'h00;
    int         press[8];

    // directed-test monitors
    int mon  = -1;
    int mon2 = -1;
    int ptimes[$];
    int p2[$];
    int lvl_cnt  = 0;
    int lvl_last = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, t);
        end
    endtask

    // Model of one rising edge: raw is seen two edges late; the level flips once the
    // last DT samples all disagree with it; pulses are due at the press and then on
    // the repeat schedule derived from the press time.
    task automatic model_edge();
        logic [7:0] s;
        bit         all_diff;
        if (!reset) begin
            rq.delete();
            sq.delete();
            m_level = 8'h00;
            m_pulse = 8'h00;
            for (int i = 0; i < 8; i++) press[i] = -100000;
        end else begin
            s = (rq.size() >= 2) ? rq[rq.size()-2] : 8'h00;
            rq.push_back(pb_raw);
            if (rq.size() > 2) void'(rq.pop_front());
            sq.push_back(s);
            if (sq.size() > DT) void'(sq.pop_front());
            for (int i = 0; i < 8; i++) begin
                if (sq.size() >= DT) begin
                    all_diff = 1'b1;
                    for (int k = 1; k <= DT; k++)
                        if (sq[sq.size()-k][i] == m_level[i]) all_diff = 1'b0;
                    if (all_diff) begin
                        m_level[i] = ~m_level[i];
                        if (m_level[i]) press[i] = t;
                    end
                end
            end
            for (int i = 0; i < 8; i++)
                m_pulse[i] = m_level[i] && ((t == press[i]) ||
                             (MASK[i] && (t >= press[i] + RD) && ((t - press[i] - RD) % RP == 0)));
        end
    endtask

    task automatic step();
        @(posedge clk);
        t++;
        model_edge();
        @(negedge clk);
        check("level", {24'h0, pb_level}, {24'h0, m_level});
        check("pulse", {24'h0, pb_pulse}, {24'h0, m_pulse});
        if (mon >= 0) begin
            if (pb_pulse[mon]) ptimes.push_back(t - t0);
            if (pb_level[mon]) begin
                lvl_cnt++;
                lvl_last = t - t0;
            end
        end
        if (mon2 >= 0 && pb_pulse[mon2]) p2.push_back(t - t0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic start_test(input int b, input int b2);
        mon = b;
        mon2 = b2;
        ptimes.delete();
        p2.delete();
        lvl_cnt  = 0;
        lvl_last = -1;
        t0 = t;
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        pb_raw = 8'h00;
        run(2);
        check("reset_level", {24'h0, pb_level}, 32'h0);
        check("reset_pulse", {24'h0, pb_pulse}, 32'h0);
        reset = 1'b1;
        run(3);
    endtask

    initial begin
        reset  = 1'b0;
        pb_raw = 8'h00;
        do_reset();

        // 1: clean press with auto-repeat, release suppresses the pulse due at 205
        start_test(5, -1);
        pb_raw[5] = 1'b1;
        run(200);
        pb_raw[5] = 1'b0;
        run(20);
        check("t1_count", ptimes.size(), 32'd16);
        if (ptimes.size() == 16)
            for (int k = 0; k < 16; k++)
                check("t1_time", ptimes[k], (k == 0) ? 32'd5 : 32'(55 + 10 * (k - 1)));
        check("t1_fall", lvl_last, 32'd204);

        // 2: bounce then steady press
        start_test(2, -1);
        for (int k = 0; k < 12; k++) begin
            pb_raw[2] = (k % 2 == 0) ? 1'b1 : 1'b0;
            step();
        end
        pb_raw[2] = 1'b1;
        run(30);
        pb_raw[2] = 1'b0;
        run(20);
        check("t2_count", ptimes.size(), 32'd1);
        if (ptimes.size() >= 1) check("t2_time", ptimes[0], 32'd17);

        // 3: two-cycle glitch is rejected
        start_test(4, -1);
        pb_raw[4] = 1'b1;
        run(2);
        pb_raw[4] = 1'b0;
        run(20);
        check("t3_pulses", ptimes.size(), 32'd0);
        check("t3_level", lvl_cnt, 32'd0);

        // 4: non-repeat button held long
        start_test(1, -1);
        pb_raw[1] = 1'b1;
        run(300);
        pb_raw[1] = 1'b0;
        run(20);
        check("t4_count", ptimes.size(), 32'd1);
        if (ptimes.size() >= 1) check("t4_time", ptimes[0], 32'd5);
        check("t4_fall", lvl_last, 32'd304);

        // 5: simultaneous presses on 3 and 6; pulse due at 125 lost to the release
        start_test(3, 6);
        pb_raw[3] = 1'b1;
        pb_raw[6] = 1'b1;
        run(120);
        pb_raw[3] = 1'b0;
        pb_raw[6] = 1'b0;
        run(20);
        check("t5_count3", ptimes.size(), 32'd8);
        check("t5_count6", p2.size(), 32'd8);
        if (ptimes.size() == 8 && p2.size() == 8)
            for (int k = 0; k < 8; k++) begin
                check("t5_time3", ptimes[k], (k == 0) ? 32'd5 : 32'(55 + 10 * (k - 1)));
                check("t5_time6", p2[k], (k == 0) ? 32'd5 : 32'(55 + 10 * (k - 1)));
            end

        // 6: reset pulse in the middle of a hold
        start_test(5, -1);
        pb_raw[5] = 1'b1;
        run(30);
        reset = 1'b0;
        step();
        check("t6_rst_level", {24'h0, pb_level}, 32'h0);
        check("t6_rst_pulse", {24'h0, pb_pulse}, 32'h0);
        reset = 1'b1;
        start_test(5, -1);
        run(70);
        pb_raw[5] = 1'b0;
        run(10);
        check("t6_count", ptimes.size(), 32'd3);
        if (ptimes.size() == 3) begin
            check("t6_first", ptimes[0], 32'd5);
            check("t6_second", ptimes[1], 32'd55);
            check("t6_third", ptimes[2], 32'd65);
        end

        // random activity on all buttons with occasional resets
        start_test(-1, -1);
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 8; i++)
                if ($urandom_range(0, 99) < 2) pb_raw[i] = ~pb_raw[i];
            reset = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
